// File: rtl/sd_host_stack_defines.sv
// Shared definitions for the SD host stack: CMD engine states, response lengths, CRC7.
package sd_host_stack_defines;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_START,
      ST_READ,
      ST_NCC,
      ST_FINISHED
   } sd_cmd_state_e;

   localparam int unsigned RSP_LEN_NONE   = 0;
   localparam int unsigned RSP_LEN_SHORT  = 40;
   localparam int unsigned RSP_LEN_LONG   = 136;
   localparam int unsigned CMD_BITS       = 40;
   localparam int unsigned CMD_FRAME_BITS = 48;
   localparam int unsigned SHORT_FRAME    = 48;
   localparam int unsigned LONG_FRAME     = 136;
   localparam logic [6:0]  CRC7_POLY      = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per enabled clk, shared by TX and RX.
module sd_crc7
   import sd_host_stack_defines::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [6:0] o_crc
);

   // LFSR update; clear wins over enable
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         o_crc <= 7'd0;
      end else if (i_en) begin
         o_crc <= {o_crc[5:0], 1'b0} ^ ({7{i_bit ^ o_crc[6]}} & CRC7_POLY);
      end
   end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line engine: sends a 48-bit command frame, captures a 48/136-bit response,
// checks its CRC7 and reports status back to the command layer.
module sd_cmd_phy
   import sd_host_stack_defines::*;
#(
   parameter int unsigned NCC_CLOCKS = 8,
   parameter int unsigned NO_RSP_LEN = RSP_LEN_NONE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_sd_clk_stb,
   input  logic         i_cmd_en,
   input  logic [39:0]  i_cmd,
   input  logic [7:0]   i_cmd_len,
   input  logic [7:0]   i_rsp_len,
   input  logic [15:0]  i_timeout,
   output logic         o_rsp_finished_en,
   output logic [135:0] o_rsp,
   output logic         o_crc_bad,
   output logic         o_timeout,
   output logic         o_sd_cmd_dir,
   output logic         o_sd_cmd,
   input  logic         i_sd_cmd
);

   sd_cmd_state_e state;
   logic [39:0]   cmd_q;
   logic          has_rsp;
   logic          is_long;
   logic [15:0]   timeout_q;
   logic [5:0]    tx_cnt;
   logic [7:0]    rx_cnt;
   logic [15:0]   to_cnt;
   logic [7:0]    ncc_cnt;

   logic [6:0]    crc;
   logic          crc_clear;
   logic          crc_en;
   logic          crc_bit;
   logic [5:0]    tx_idx;
   logic [2:0]    crc_idx;
   logic          tx_bit;
   logic [7:0]    rx_last;
   logic [7:0]    crc_lo;
   logic [7:0]    crc_hi;

   // The frame length is fixed at 40+8 bits, so the command length is informational only
   logic unused_cmd_len;
   assign unused_cmd_len = ^i_cmd_len;

   sd_crc7 u_crc7 (
      .clk     (clk),
      .rst     (rst),
      .i_clear (crc_clear),
      .i_en    (crc_en),
      .i_bit   (crc_bit),
      .o_crc   (crc)
   );

   // Transmit bit selection and CRC feed control
   always_comb begin
      tx_idx    = 6'(6'd39 - tx_cnt);
      crc_idx   = 3'(6'd46 - tx_cnt);
      rx_last   = is_long ? 8'(LONG_FRAME - 1) : 8'(SHORT_FRAME - 1);
      crc_lo    = is_long ? 8'd8 : 8'd0;
      crc_hi    = is_long ? 8'(LONG_FRAME - 8) : 8'(SHORT_FRAME - 8);
      tx_bit    = 1'b1;
      crc_bit   = 1'b0;
      crc_en    = 1'b0;
      crc_clear = 1'b0;
      if (tx_cnt < 6'(CMD_BITS)) begin
         tx_bit = cmd_q[tx_idx];
      end else if (tx_cnt < 6'(CMD_FRAME_BITS - 1)) begin
         tx_bit = crc[crc_idx];
      end
      case (state)
         ST_IDLE: crc_clear = i_cmd_en;
         ST_SEND: begin
            crc_bit = tx_bit;
            crc_en  = i_cmd_en && i_sd_clk_stb && (tx_cnt < 6'(CMD_BITS));
            // CRC is free once the remainder is on the wire; restart it for the response
            crc_clear = i_sd_clk_stb && (tx_cnt == 6'(CMD_FRAME_BITS));
         end
         ST_WAIT_START: begin
            // Short-response CRC covers the start bit; long-response CRC skips the header
            crc_bit = i_sd_cmd;
            crc_en  = i_cmd_en && i_sd_clk_stb && !i_sd_cmd && !is_long;
         end
         ST_READ: begin
            crc_bit = i_sd_cmd;
            crc_en  = i_cmd_en && i_sd_clk_stb && (rx_cnt >= crc_lo) && (rx_cnt < crc_hi);
         end
         default: ;
      endcase
   end

   // Transaction state machine with registered pin and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         cmd_q             <= 40'd0;
         has_rsp           <= 1'b0;
         is_long           <= 1'b0;
         timeout_q         <= 16'd0;
         tx_cnt            <= 6'd0;
         rx_cnt            <= 8'd0;
         to_cnt            <= 16'd0;
         ncc_cnt           <= 8'd0;
         o_rsp_finished_en <= 1'b0;
         o_rsp             <= 136'd0;
         o_crc_bad         <= 1'b0;
         o_timeout         <= 1'b0;
         o_sd_cmd_dir      <= 1'b0;
         o_sd_cmd          <= 1'b1;
      end else if (!i_cmd_en && (state != ST_IDLE)) begin
         state             <= ST_IDLE;
         o_sd_cmd_dir      <= 1'b0;
         o_sd_cmd          <= 1'b1;
         o_rsp_finished_en <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_sd_cmd_dir      <= 1'b0;
               o_sd_cmd          <= 1'b1;
               o_rsp_finished_en <= 1'b0;
               o_crc_bad         <= 1'b0;
               o_timeout         <= 1'b0;
               if (i_cmd_en) begin
                  cmd_q     <= i_cmd;
                  has_rsp   <= (i_rsp_len != 8'(NO_RSP_LEN));
                  is_long   <= (i_rsp_len == 8'(RSP_LEN_LONG));
                  timeout_q <= i_timeout;
                  o_rsp     <= 136'd0;
                  tx_cnt    <= 6'd0;
                  ncc_cnt   <= 8'd0;
                  state     <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (i_sd_clk_stb) begin
                  if (tx_cnt == 6'(CMD_FRAME_BITS)) begin
                     o_sd_cmd_dir <= 1'b0;
                     o_sd_cmd     <= 1'b1;
                     to_cnt       <= 16'd0;
                     state        <= has_rsp ? ST_WAIT_START : ST_NCC;
                  end else begin
                     o_sd_cmd_dir <= 1'b1;
                     o_sd_cmd     <= tx_bit;
                     tx_cnt       <= tx_cnt + 6'd1;
                  end
               end
            end
            ST_WAIT_START: begin
               if (i_sd_clk_stb) begin
                  if (!i_sd_cmd) begin
                     o_rsp  <= {o_rsp[134:0], 1'b0};
                     rx_cnt <= 8'd1;
                     state  <= ST_READ;
                  end else if (to_cnt == timeout_q) begin
                     o_timeout <= 1'b1;
                     state     <= ST_NCC;
                  end else begin
                     to_cnt <= to_cnt + 16'd1;
                  end
               end
            end
            ST_READ: begin
               if (i_sd_clk_stb) begin
                  o_rsp  <= {o_rsp[134:0], i_sd_cmd};
                  rx_cnt <= rx_cnt + 8'd1;
                  if (rx_cnt == rx_last) begin
                     // o_rsp[6:0] holds received bits 7..1 before this final shift
                     o_crc_bad <= (o_rsp[6:0] != crc) || !i_sd_cmd;
                     state     <= ST_NCC;
                  end
               end
            end
            ST_NCC: begin
               if (i_sd_clk_stb) begin
                  if (ncc_cnt == 8'(NCC_CLOCKS - 1)) begin
                     o_rsp_finished_en <= 1'b1;
                     state             <= ST_FINISHED;
                  end else begin
                     ncc_cnt <= ncc_cnt + 8'd1;
                  end
               end
            end
            ST_FINISHED: begin
               o_rsp_finished_en <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Self-checking bench for sd_cmd_phy: directed protocol cases plus randomized transactions
// checked against a polynomial-division CRC7 model and a simple card model.
module tb_sd_cmd_phy;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_sd_clk_stb;
   logic         i_cmd_en;
   logic [39:0]  i_cmd;
   logic [7:0]   i_cmd_len;
   logic [7:0]   i_rsp_len;
   logic [15:0]  i_timeout;
   logic         o_rsp_finished_en;
   logic [135:0] o_rsp;
   logic         o_crc_bad;
   logic         o_timeout;
   logic         o_sd_cmd_dir;
   logic         o_sd_cmd;
   logic         i_sd_cmd;

   int n_checks = 0;
   int n_pass   = 0;
   logic [47:0]  last_tx;
   logic [135:0] last_rsp;

   sd_cmd_phy dut (
      .clk               (clk),
      .rst               (rst),
      .i_sd_clk_stb      (i_sd_clk_stb),
      .i_cmd_en          (i_cmd_en),
      .i_cmd             (i_cmd),
      .i_cmd_len         (i_cmd_len),
      .i_rsp_len         (i_rsp_len),
      .i_timeout         (i_timeout),
      .o_rsp_finished_en (o_rsp_finished_en),
      .o_rsp             (o_rsp),
      .o_crc_bad         (o_crc_bad),
      .o_timeout         (o_timeout),
      .o_sd_cmd_dir      (o_sd_cmd_dir),
      .o_sd_cmd          (o_sd_cmd),
      .i_sd_cmd          (i_sd_cmd)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1 (n message bits, right-aligned)
   function automatic logic [6:0] crc7_div(input logic [119:0] data, input int n);
      logic [126:0] r;
      r = {data, 7'd0};
      for (int i = n + 6; i >= 7; i--) begin
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      end
      return r[6:0];
   endfunction

   function automatic logic [135:0] build_short(input logic [39:0] body);
      return 136'({body, crc7_div(120'(body), 40), 1'b1});
   endfunction

   function automatic logic [135:0] build_long(input logic [119:0] payload);
      return {8'h3F, payload, crc7_div(payload, 120), 1'b1};
   endfunction

   task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One SD clock period: three idle clks, strobe on the fourth; returns #1 after that edge
   task automatic strobe();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      i_sd_clk_stb = 1'b1;
      @(posedge clk);
      #1;
      i_sd_clk_stb = 1'b0;
   endtask

   // Full transaction with card model; d = WAIT strobe index carrying the start bit (0 = silent)
   task automatic run_txn(input logic [39:0] cmd, input logic [7:0] rlen, input logic [15:0] tmo,
                          input int d, input logic [135:0] frame, input int abort_at);
      logic [47:0]  tx_exp;
      logic [47:0]  tx_got;
      logic [135:0] exp_rsp;
      logic         dir_ok;
      logic         taken;
      logic         exp_bad;
      int           n;
      int           x;
      tx_exp = {cmd, crc7_div(120'(cmd), 40), 1'b1};
      n      = (rlen == 8'd136) ? 136 : 48;
      i_cmd = cmd; i_rsp_len = rlen; i_timeout = tmo; i_sd_cmd = 1'b1; i_cmd_en = 1'b1;
      @(posedge clk);
      #1;
      dir_ok = 1'b1;
      tx_got = 48'd0;
      for (int b = 0; b < 48; b++) begin
         strobe();
         tx_got = {tx_got[46:0], o_sd_cmd};
         if (!o_sd_cmd_dir) dir_ok = 1'b0;
         if (abort_at == b + 1) begin
            i_cmd_en = 1'b0;
            @(posedge clk);
            #1;
            check("abort_dir", 136'(o_sd_cmd_dir), 136'(0));
            check("abort_cmd", 136'(o_sd_cmd), 136'(1));
            check("abort_fin", 136'(o_rsp_finished_en), 136'(0));
            repeat (60) strobe();
            check("abort_no_fin", 136'(o_rsp_finished_en), 136'(0));
            check("abort_dir_hold", 136'(o_sd_cmd_dir), 136'(0));
            return;
         end
      end
      check("tx_frame", 136'(tx_got), 136'(tx_exp));
      check("tx_dir", 136'(dir_ok), 136'(1));
      strobe();
      check("rel_dir", 136'(o_sd_cmd_dir), 136'(0));
      check("rel_cmd", 136'(o_sd_cmd), 136'(1));
      taken   = (rlen != 8'd0) && (d >= 1) && (d <= int'(tmo) + 1);
      x       = taken ? (d - 1 + n) : ((rlen != 8'd0) ? int'(tmo) + 1 : 0);
      exp_rsp = taken ? frame : 136'd0;
      if (n == 48) exp_bad = taken && ((frame[7:1] != crc7_div(120'(frame[47:8]), 40)) || !frame[0]);
      else         exp_bad = taken && ((frame[7:1] != crc7_div(frame[127:8], 120)) || !frame[0]);
      for (int s = 1; s <= x + 8; s++) begin
         if ((rlen != 8'd0) && (d >= 1) && (s >= d) && (s - d < n)) i_sd_cmd = frame[n - 1 - (s - d)];
         else i_sd_cmd = 1'b1;
         strobe();
         if (s == x + 7) check("fin_early", 136'(o_rsp_finished_en), 136'(0));
      end
      i_sd_cmd = 1'b1;
      check("fin", 136'(o_rsp_finished_en), 136'(1));
      check("rsp", o_rsp, exp_rsp);
      check("crc_bad", 136'(o_crc_bad), 136'(exp_bad));
      check("timeout", 136'(o_timeout), 136'((rlen != 8'd0) && !taken));
      last_tx  = tx_got;
      last_rsp = o_rsp;
      repeat (3) strobe();
      check("fin_hold", 136'(o_rsp_finished_en), 136'(1));
      check("rsp_hold", o_rsp, exp_rsp);
      i_cmd_en = 1'b0;
      @(posedge clk);
      #1;
      check("fin_drop", 136'(o_rsp_finished_en), 136'(0));
   endtask

   initial begin
      logic [135:0] frame;
      logic [127:0] rnd;
      logic [7:0]   rlen;
      int           k;
      int           n;
      rst = 1'b1; i_sd_clk_stb = 1'b0; i_cmd_en = 1'b0; i_cmd = 40'd0; i_cmd_len = 8'd40;
      i_rsp_len = 8'd0; i_timeout = 16'd0; i_sd_cmd = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_fin", 136'(o_rsp_finished_en), 136'(0));
      check("rst_crc", 136'(o_crc_bad), 136'(0));
      check("rst_to", 136'(o_timeout), 136'(0));
      check("rst_dir", 136'(o_sd_cmd_dir), 136'(0));
      check("rst_cmd", 136'(o_sd_cmd), 136'(1));
      check("rst_rsp", o_rsp, 136'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // CMD0, no response
      run_txn(40'h40_0000_0000, 8'd0, 16'd0, 0, 136'd0, -1);
      check("cmd0_wire", 136'(last_tx), 136'(48'h40_0000_0000_95));

      // CMD8 with R7 response after 5 strobes
      frame = build_short(40'h08_0000_01AA);
      run_txn(40'h48_0000_01AA, 8'd40, 16'd100, 5, frame, -1);
      check("cmd8_wire", 136'(last_tx), 136'(48'h48_0000_01AA_87));
      check("cmd8_rsp", last_rsp, 136'(48'h08_0000_01AA_13));

      // Same response with bit 3 flipped
      run_txn(40'h48_0000_01AA, 8'd40, 16'd100, 5, frame ^ 136'(8), -1);
      check("cmd8_bad_rsp", last_rsp, 136'(48'h08_0000_01AA_1B));

      // No card response, timeout 64; also timeout 0
      run_txn(40'h77_0000_0000, 8'd40, 16'd64, 0, 136'd0, -1);
      run_txn(40'h77_0000_0000, 8'd40, 16'd0, 0, 136'd0, -1);

      // Start bit exactly at the last allowed strobe
      run_txn(40'h48_0000_01AA, 8'd40, 16'd3, 4, frame, -1);

      // Long R2 response
      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_txn(40'h42_0000_0000, 8'd136, 16'd20, 2, build_long(rnd[119:0]), -1);

      // Abort during SEND, then a clean request
      run_txn(40'h51_1234_5678, 8'd40, 16'd10, 3, frame, 20);
      run_txn(40'h48_0000_01AA, 8'd40, 16'd100, 1, frame, -1);
      check("post_abort_wire", 136'(last_tx), 136'(48'h48_0000_01AA_87));

      // Randomized transactions
      for (int t = 0; t < 10; t++) begin
         k    = int'($urandom_range(0, 2));
         rlen = (k == 0) ? 8'd0 : ((k == 1) ? 8'd40 : 8'd136);
         n    = (k == 2) ? 136 : 48;
         rnd  = {$urandom, $urandom, $urandom, $urandom};
         frame = (k == 2) ? build_long(rnd[119:0]) : build_short({2'b00, rnd[37:0]});
         if ($urandom_range(0, 2) == 0) frame = frame ^ (136'd1 << $urandom_range(0, n - 2));
         run_txn({2'b01, rnd[127:90]}, rlen, 16'($urandom_range(0, 12)),
                 int'($urandom_range(1, 16)), frame, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sd_cmd_phy.md
Name: sd_cmd_phy

Overview:
Serial CMD-line engine of the SD host stack, directly downstream of the SD command layer. Takes a 40-bit command frame, appends CRC7 and the end bit, and shifts the 48-bit frame onto the SD CMD pin. It then releases the pin, waits for a response start bit with a timeout, and captures a 48- or 136-bit response. Finally it checks the response CRC7 and returns the response and status to the command layer.

Parameters:
NCC_CLOCKS, 8, idle SD clocks inserted after a transaction completes, before FINISHED.
NO_RSP_LEN, 0, i_rsp_len value that means the command has no response.

Ports:
clk  in  1  system clock
rst  in  1  reset
i_sd_clk_stb  in  1  one-clk strobe per SD clock period; every CMD bit drive and sample happens only on strobe cycles
i_cmd_en  in  1  level request; held high by the command layer until it sees o_rsp_finished_en
i_cmd  in  40  command frame: start bit, transmit bit, index, argument
i_cmd_len  in  8  command bits before CRC; always 40
i_rsp_len  in  8  0 = no response, 40 = short response (48-bit frame), 136 = long response (136-bit frame)
i_timeout  in  16  SD clocks allowed between command end bit and response start bit
o_rsp_finished_en  out  1  transaction done; held high until i_cmd_en falls
o_rsp  out  136  received frame, right-aligned, start bit through end bit
o_crc_bad  out  1  response CRC7 mismatch, or end bit equal to 0
o_timeout  out  1  no start bit seen within i_timeout
o_sd_cmd_dir  out  1  1 = host drives the CMD pin
o_sd_cmd  out  1  CMD pin output value
i_sd_cmd  in  1  CMD pin input, synchronised externally

Behaviour:
- Reset is rst: synchronous, active-high, on clock clk.
- Reset values: state IDLE; o_rsp_finished_en, o_crc_bad, o_timeout, o_sd_cmd_dir = 0; o_sd_cmd = 1; o_rsp = 0.
- IDLE:
  - o_sd_cmd_dir = 0; status outputs cleared.
  - On i_cmd_en: latch i_cmd, i_rsp_len, i_timeout; clear o_rsp, o_crc_bad, o_timeout; reset CRC; go to SEND.
- SEND:
  - On each strobe, drive the next bit MSB-first, with o_sd_cmd_dir = 1.
  - Bits 47..8 come from the latched command and feed the CRC7.
  - Bits 7..1 are the CRC7 remainder; bit 0 = 1 (end bit).
  - Bit counter is 6 bits.
  - On the strobe after the end bit: dir = 0, o_sd_cmd = 1, timeout counter = 0.
    - If rsp_len = NO_RSP_LEN, go to NCC.
    - Otherwise go to WAIT_START.
- WAIT_START:
  - On each strobe: if i_sd_cmd = 0, shift the 0 into o_rsp, reset CRC, go to READ.
  - Else increment the timeout counter.
  - When counter == latched timeout: o_timeout = 1, go to NCC.
  - A timeout value of 0 means an immediate timeout on the first strobe that has no start bit.
- READ:
  - Shift i_sd_cmd into o_rsp LSB on each strobe.
  - Frame length N = 48 for short responses, 136 for long.
  - CRC7 input:
    - Short: frame bits 47..8.
    - Long: frame bits 127..8; the 8 header bits are excluded.
  - After bit 0 is captured: o_crc_bad = (received bits 7..1 != computed CRC) or (bit 0 == 0). Go to NCC.
- NCC:
  - Count NCC_CLOCKS strobes with dir = 0, then go to FINISHED.
- FINISHED:
  - o_rsp_finished_en = 1. o_rsp, o_crc_bad, o_timeout are stable while it is high.
- Abort: i_cmd_en low in any state returns to IDLE on the next clk.
  - dir = 0 in the same transition; o_rsp_finished_en drops.
  - No partial-frame completion is reported.
- A new request needs i_cmd_en to be low for at least one clk first; holding it high after FINISHED does not retrigger.
- No strobe means no progress; the state machine holds with no counting.
- i_cmd_len is ignored beyond documentation; the frame is always 40+8 bits.

Decomposition:
- Shared package sd_host_stack_defines:
  - state encodings
  - RSP_LEN_NONE/SHORT/LONG (0/40/136)
  - CMD_FRAME_BITS = 48
  - CRC7_POLY = 7'h09
- Sub-module sd_crc7:
  - Serial CRC7, polynomial x^7+x^3+1.
  - Ports: clk, rst, i_clear, i_en, i_bit, o_crc[6:0].
  - Updates on i_en; zero on i_clear.
  - Instantiated once and shared between TX and RX phases.

Test Plan:
- CMD0, arg 0, rsp_len 0 -> CMD pin carries 0x40_0000_0000_95 MSB-first over 48 strobes; dir falls after the end bit; finished after 8 more strobes; crc_bad = 0, timeout = 0.
- CMD8, arg 0x1AA, rsp_len 40; card model returns 0x08_0000_01AA_13 after 5 strobes -> TX frame 0x48_0000_01AA_87; o_rsp[47:0] = 0x08000001AA13; crc_bad = 0.
- Same as above with response bit 3 flipped -> o_crc_bad = 1, finished asserted, o_rsp holds the corrupted frame.
- rsp_len 40, i_timeout 64, CMD line held high -> o_timeout = 1 after 64 strobes of waiting, plus 8 NCC strobes, then finished.
- rsp_len 136; card model sends an R2 frame with valid CRC over bits 127..8 -> o_rsp[135:0] matches the frame bit-exact; crc_bad = 0.
- i_cmd_en dropped at bit 20 of SEND -> next clk: IDLE, dir = 0, o_sd_cmd = 1, no finished pulse; a following request transmits cleanly.
